key_param_ctrl: RTL and testbench

Consumes debounced key events (one-cycle `key_flag` plus active-high `key_value`) from the key debounce stage. Turns them into image-processing configuration: a processing-mode select and a per-mode 8-bit threshold. Edits go to live registers immediately, but reach the pipeline-facing outputs only at the next frame start (rising edge of `vsync`). This keeps the mode and threshold constant for the whole of every frame.

---
 rtl/key_param_ctrl_if.sv | 24 ++
 rtl/key_param_ctrl.sv | 94 +++++++++
 tb/tb_key_param_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_param_ctrl_if.sv
// Key-event and applied-configuration bundle between the debounce stage,
// the video timing and key_param_ctrl.
interface key_param_ctrl_if #(
    parameter int MODE_W = 2,
    parameter int TH_W   = 8
);
    logic              key_flag;
    logic [2:0]        key_value;
    logic              vsync;
    logic [MODE_W-1:0] mode_out;
    logic [TH_W-1:0]   thresh_out;
    logic              cfg_pending;
    logic              cfg_update;

    modport master (
        output key_flag, key_value, vsync,
        input  mode_out, thresh_out, cfg_pending, cfg_update
    );

    modport slave (
        input  key_flag, key_value, vsync,
        output mode_out, thresh_out, cfg_pending, cfg_update
    );
endinterface

// File: rtl/key_param_ctrl.sv
// Key-driven mode/threshold editor; edits are live at once but only
// reach the pipeline outputs on the next rising edge of vsync.
module key_param_ctrl #(
    parameter int MODE_NUM = 4,
    parameter int MODE_W   = 2,
    parameter int TH_W     = 8,
    parameter int TH_STEP  = 8,
    parameter int TH_MAX   = 255,
    parameter int TH_INIT  = 64
) (
    input logic            clk,
    input logic            rst_n,
    key_param_ctrl_if.slave bus
);
    localparam logic [TH_W:0]     STEP_X = (TH_W+1)'(TH_STEP);
    localparam logic [TH_W:0]     MAX_X  = (TH_W+1)'(TH_MAX);
    localparam logic [TH_W-1:0]   INIT_V = TH_W'(TH_INIT);
    localparam logic [MODE_W-1:0] LAST_M = MODE_W'(MODE_NUM - 1);

    logic [MODE_W-1:0] live_mode;
    logic [MODE_W-1:0] mode_q;
    logic [TH_W-1:0]   th [MODE_NUM];
    logic [TH_W-1:0]   thresh_q;
    logic [TH_W-1:0]   th_cur;
    logic [TH_W-1:0]   th_next;
    logic [TH_W:0]     th_sum;
    logic              vsync_r;
    logic              pending_q;
    logic              update_q;
    logic              is_inc;
    logic              is_dec;
    logic              is_nxt;
    logic              cmd_ok;
    logic              frame_start;
    logic              apply;

    assign is_inc      = bus.key_flag && (bus.key_value == 3'b001);
    assign is_dec      = bus.key_flag && (bus.key_value == 3'b010);
    assign is_nxt      = bus.key_flag && (bus.key_value == 3'b100);
    assign cmd_ok      = is_inc | is_dec | is_nxt;
    assign frame_start = bus.vsync & ~vsync_r;
    assign apply       = frame_start & pending_q;
    assign th_cur      = th[live_mode];
    assign th_sum      = {1'b0, th_cur} + STEP_X;

    // Saturating step, evaluated one bit wider so the sum cannot wrap
    always_comb begin
        th_next = th_cur;
        unique case (1'b1)
            is_inc: th_next = (th_sum > MAX_X) ? MAX_X[TH_W-1:0]
                                               : th_sum[TH_W-1:0];
            is_dec: th_next = ({1'b0, th_cur} < STEP_X) ? '0
                            : th_cur - STEP_X[TH_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_mode <= '0;
            for (int i = 0; i < MODE_NUM; i++) th[i] <= INIT_V;
        end else begin
            if (is_inc || is_dec) th[live_mode] <= th_next;
            if (is_nxt)
                live_mode <= (live_mode == LAST_M) ? '0
                                                   : live_mode + 1'b1;
        end
    end

    // Apply samples pre-key live values; a colliding key stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r   <= 1'b0;
            mode_q    <= '0;
            thresh_q  <= INIT_V;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            vsync_r  <= bus.vsync;
            update_q <= apply;
            if (apply) begin
                mode_q   <= live_mode;
                thresh_q <= th_cur;
            end
            if (cmd_ok)     pending_q <= 1'b1;
            else if (apply) pending_q <= 1'b0;
        end
    end

    assign bus.mode_out    = mode_q;
    assign bus.thresh_out  = thresh_q;
    assign bus.cfg_pending = pending_q;
    assign bus.cfg_update  = update_q;
endmodule

// File: tb/tb_key_param_ctrl.sv
// Randomised + directed bench for key_param_ctrl against an
// integer-level model of the live/applied configuration.
module tb_key_param_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    bit   cmp_en;

    key_param_ctrl_if #(.MODE_W(2), .TH_W(8)) bus ();

    key_param_ctrl #(
        .MODE_NUM(4), .MODE_W(2), .TH_W(8),
        .TH_STEP(8), .TH_MAX(255), .TH_INIT(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: plain integers, stepped on each clock edge
    int  m_th [4];
    int  m_mode;
    int  a_mode;
    int  a_th;
    bit  m_pend;
    bit  m_upd;
    bit  m_vprev;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_th[i] = 64;
        m_mode  = 0;
        a_mode  = 0;
        a_th    = 64;
        m_pend  = 0;
        m_upd   = 0;
        m_vprev = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                bit fs;
                fs      = bus.vsync && !m_vprev;
                m_vprev = bus.vsync;
                m_upd   = 0;
                if (fs && m_pend) begin
                    a_mode = m_mode;
                    a_th   = m_th[m_mode];
                    m_upd  = 1;
                    m_pend = 0;
                end
                if (bus.key_flag) begin
                    case (bus.key_value)
                        3'b001: begin
                            m_th[m_mode] = (m_th[m_mode] + 8 > 255)
                                           ? 255 : m_th[m_mode] + 8;
                            m_pend = 1;
                        end
                        3'b010: begin
                            m_th[m_mode] = (m_th[m_mode] - 8 < 0)
                                           ? 0 : m_th[m_mode] - 8;
                            m_pend = 1;
                        end
                        3'b100: begin
                            m_mode = (m_mode + 1) % 4;
                            m_pend = 1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, half a cycle away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("mode_out", int'(bus.mode_out), a_mode);
                chk("thresh_out", int'(bus.thresh_out), a_th);
                chk("cfg_pending", int'(bus.cfg_pending), int'(m_pend));
                chk("cfg_update", int'(bus.cfg_update), int'(m_upd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [2:0] v);
        bus.key_flag  = 1'b1;
        bus.key_value = v;
        step();
        bus.key_flag  = 1'b0;
        bus.key_value = 3'($urandom_range(0, 7));
    endtask

    task automatic frame(output int pulses);
        pulses = 0;
        bus.vsync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.cfg_update) pulses++;
        end
        bus.vsync = 1'b0;
        step();
        if (bus.cfg_update) pulses++;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    int p;

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        cmp_en        = 0;
        rst_n         = 1'b0;
        bus.key_flag  = 1'b0;
        bus.key_value = 3'b000;
        bus.vsync     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cmp_en = 1;
        step();

        // reset state, then an idle frame
        chk("rst mode", int'(bus.mode_out), 0);
        chk("rst thresh", int'(bus.thresh_out), 64);
        chk("rst pending", int'(bus.cfg_pending), 0);
        frame(p);
        chk("idle frame pulses", p, 0);
        chk("idle thresh", int'(bus.thresh_out), 64);

        // three increments
        press(3'b001);
        chk("inc pending", int'(bus.cfg_pending), 1);
        press(3'b001);
        press(3'b001);
        chk("inc pre-edge thresh", int'(bus.thresh_out), 64);
        frame(p);
        chk("inc pulses", p, 1);
        chk("inc thresh", int'(bus.thresh_out), 88);

        // saturation both ways
        for (int i = 0; i < 30; i++) press(3'b001);
        frame(p);
        chk("sat hi thresh", int'(bus.thresh_out), 255);
        press(3'b001);
        chk("sat hi pending", int'(bus.cfg_pending), 1);
        frame(p);
        chk("sat hi reapply", p, 1);
        for (int i = 0; i < 40; i++) press(3'b010);
        frame(p);
        chk("sat lo thresh", int'(bus.thresh_out), 0);
        press(3'b010);
        chk("sat lo pending", int'(bus.cfg_pending), 1);
        frame(p);

        // per-mode thresholds and mode wrap
        do_reset();
        press(3'b001);
        press(3'b100);
        press(3'b010);
        frame(p);
        chk("mode1 mode", int'(bus.mode_out), 1);
        chk("mode1 thresh", int'(bus.thresh_out), 56);
        press(3'b100);
        press(3'b100);
        press(3'b100);
        frame(p);
        chk("wrap mode", int'(bus.mode_out), 0);
        chk("wrap thresh", int'(bus.thresh_out), 72);

        // illegal codes
        do_reset();
        press(3'b011);
        press(3'b110);
        press(3'b000);
        chk("illegal pending", int'(bus.cfg_pending), 0);
        frame(p);
        chk("illegal pulses", p, 0);
        chk("illegal thresh", int'(bus.thresh_out), 64);

        // key in the same cycle as the frame-start edge
        do_reset();
        bus.vsync     = 1'b1;
        bus.key_flag  = 1'b1;
        bus.key_value = 3'b001;
        step();
        bus.key_flag  = 1'b0;
        chk("collide update", int'(bus.cfg_update), 0);
        chk("collide pending", int'(bus.cfg_pending), 1);
        step();
        bus.vsync = 1'b0;
        step();
        frame(p);
        chk("collide pulses", p, 1);
        chk("collide thresh", int'(bus.thresh_out), 72);

        // asynchronous reset mid-frame
        press(3'b100);
        press(3'b001);
        frame(p);
        chk("pre-rst mode", int'(bus.mode_out), 1);
        press(3'b001);
        bus.vsync = 1'b1;
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("async mode", int'(bus.mode_out), 0);
        chk("async thresh", int'(bus.thresh_out), 64);
        chk("async pending", int'(bus.cfg_pending), 0);
        chk("async update", int'(bus.cfg_update), 0);
        step();
        bus.vsync = 1'b0;
        rst_n = 1'b1;
        step();

        // randomised traffic, including back-to-back keys
        for (int c = 0; c < 4000; c++) begin
            bus.key_flag = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 7)
                bus.key_value = 3'(1 << $urandom_range(0, 2));
            else
                bus.key_value = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) bus.vsync = ~bus.vsync;
            if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        bus.key_flag = 1'b0;
        step();
        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
